// File: rtl/instruction_fetch_unit_pkg.sv
// rtl/instruction_fetch_unit_pkg.sv - constants and fetch FSM encoding shared by fetch and decode
package instruction_fetch_unit_pkg;

   localparam int INSTRUCTION_WIDTH = 16;
   localparam int OS_START          = 2048;

   // All-ones makes the decoder present its reset ID until the first fetch lands.
   localparam logic [15:0] RESET_INSTRUCTION = 16'hffff;
   localparam logic [15:0] NOP_INSTRUCTION   = 16'h0000;

   typedef enum logic [1:0] {
      ST_BOOT   = 2'd0,
      ST_FETCH  = 2'd1,
      ST_VALID  = 2'd2,
      ST_HALTED = 2'd3
   } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - PC, imem handshake and instruction register feeding the decoder
// Optional macro FETCH_STALL_COUNTER_EN adds the stall_cycles counter output.
module instruction_fetch_unit
   import instruction_fetch_unit_pkg::*;
#(
   parameter int                    INSTRUCTION_WIDTH = instruction_fetch_unit_pkg::INSTRUCTION_WIDTH,
   parameter int                    ADDR_WIDTH        = 16,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC          = '0
) (
   input  logic                         clock,
   input  logic                         reset,
   output logic                         imem_req,
   output logic [ADDR_WIDTH-1:0]        imem_addr,
   input  logic                         imem_ack,
   input  logic [INSTRUCTION_WIDTH-1:0] imem_rdata,
   input  logic                         decode_ready,
   input  logic                         redirect_valid,
   input  logic [ADDR_WIDTH-1:0]        redirect_pc,
   input  logic                         halt,
   input  logic                         resume,
   input  logic                         os_enter,
   output logic [INSTRUCTION_WIDTH-1:0] Instruction,
   output logic                         instr_valid,
   output logic [ADDR_WIDTH-1:0]        instr_pc,
   output logic                         is_bios,
   output logic                         halted
`ifdef FETCH_STALL_COUNTER_EN
   ,
   output logic [31:0]                  stall_cycles
`endif
);

   fetch_state_t          state, state_next;
   logic [ADDR_WIDTH-1:0] pc, pc_next;
   logic                  capture;

   // Redirect and halt pre-empt every state, so any same-cycle ack is dropped.
   always_comb begin
      state_next = state;
      pc_next    = pc;
      capture    = 1'b0;
      if (redirect_valid) begin
         state_next = ST_FETCH;
         pc_next    = redirect_pc;
      end else if (halt) begin
         state_next = ST_HALTED;
      end else begin
         case (state)
            ST_BOOT:   state_next = ST_FETCH;
            ST_FETCH:  if (imem_ack) begin
                          capture    = 1'b1;
                          pc_next    = pc + ADDR_WIDTH'(1);
                          state_next = ST_VALID;
                       end
            ST_VALID:  if (decode_ready) state_next = ST_FETCH;
            ST_HALTED: if (resume) state_next = ST_FETCH;
            default:   state_next = ST_BOOT;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state       <= ST_BOOT;
         pc          <= RESET_PC;
         Instruction <= INSTRUCTION_WIDTH'(RESET_INSTRUCTION);
         instr_pc    <= '0;
         is_bios     <= 1'b1;
      end else begin
         state <= state_next;
         pc    <= pc_next;
         if (capture) begin
            Instruction <= imem_rdata;
            instr_pc    <= pc;
         end
         if (os_enter) is_bios <= 1'b0;
      end
   end

   assign imem_req    = (state == ST_FETCH) && !redirect_valid;
   assign imem_addr   = pc;
   assign instr_valid = (state == ST_VALID);
   assign halted      = (state == ST_HALTED);

`ifdef FETCH_STALL_COUNTER_EN
   logic stall_now;
   assign stall_now = (imem_req && !imem_ack) || ((state == ST_VALID) && !decode_ready);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         stall_cycles <= '0;
      end else if (stall_now && (stall_cycles != 32'hffff_ffff)) begin
         stall_cycles <= stall_cycles + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - vector table, corner sequences and randomized model check
module tb_instruction_fetch_unit;
   import instruction_fetch_unit_pkg::*;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [15:0] imem_rdata = '0;
   logic        decode_ready = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [15:0] redirect_pc = '0;
   logic        halt = 1'b0;
   logic        resume = 1'b0;
   logic        os_enter = 1'b0;
   logic [15:0] Instruction;
   logic        instr_valid;
   logic [15:0] instr_pc;
   logic        is_bios;
   logic        halted;
`ifdef FETCH_STALL_COUNTER_EN
   logic [31:0] stall_cycles;
`endif

   instruction_fetch_unit dut (
      .clock(clock), .reset(reset),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .decode_ready(decode_ready), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .halt(halt), .resume(resume), .os_enter(os_enter),
      .Instruction(Instruction), .instr_valid(instr_valid), .instr_pc(instr_pc),
      .is_bios(is_bios), .halted(halted)
`ifdef FETCH_STALL_COUNTER_EN
      , .stall_cycles(stall_cycles)
`endif
   );

   always #5 clock = ~clock;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic        rv;
      logic [15:0] rpc;
      logic        hlt, res, ack;
      logic [15:0] rd;
      logic        rdy, ose;
      logic        e_req;
      logic [15:0] e_addr;
      logic        e_val;
      logic [15:0] e_ins, e_ipc;
      logic        e_hlt, e_bios;
   } vec_t;

   vec_t vt[15];

   function automatic vec_t mk(logic rv, logic [15:0] rpc, logic hlt, logic res, logic ack,
                               logic [15:0] rd, logic rdy, logic ose, logic e_req,
                               logic [15:0] e_addr, logic e_val, logic [15:0] e_ins,
                               logic [15:0] e_ipc, logic e_hlt, logic e_bios);
      vec_t v;
      v.rv = rv; v.rpc = rpc; v.hlt = hlt; v.res = res; v.ack = ack; v.rd = rd;
      v.rdy = rdy; v.ose = ose; v.e_req = e_req; v.e_addr = e_addr; v.e_val = e_val;
      v.e_ins = e_ins; v.e_ipc = e_ipc; v.e_hlt = e_hlt; v.e_bios = e_bios;
      return v;
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_out(string tag, logic e_req, logic [15:0] e_addr, logic e_val,
                            logic [15:0] e_ins, logic [15:0] e_ipc, logic e_hlt, logic e_bios);
      check({tag, " imem_req"}, 32'(imem_req), 32'(e_req));
      if (e_req) check({tag, " imem_addr"}, 32'(imem_addr), 32'(e_addr));
      check({tag, " instr_valid"}, 32'(instr_valid), 32'(e_val));
      check({tag, " Instruction"}, 32'(Instruction), 32'(e_ins));
      check({tag, " instr_pc"}, 32'(instr_pc), 32'(e_ipc));
      check({tag, " halted"}, 32'(halted), 32'(e_hlt));
      check({tag, " is_bios"}, 32'(is_bios), 32'(e_bios));
   endtask

   task automatic drive(logic rv, logic [15:0] rpc, logic hlt, logic res, logic ack,
                        logic [15:0] rd, logic rdy, logic ose);
      redirect_valid = rv; redirect_pc = rpc; halt = hlt; resume = res;
      imem_ack = ack; imem_rdata = rd; decode_ready = rdy; os_enter = ose;
   endtask

   task automatic next_cycle();
      @(posedge clock);
      #1;
   endtask

   function automatic logic [15:0] mem_word(logic [15:0] a);
      return (a * 16'h9e37) ^ 16'h5a5a;
   endfunction

   // Reference model state: what the fetch stage holds, not how it encodes it
   logic        m_boot, m_halted, m_hold, m_bios;
   logic [15:0] m_pc, m_instr, m_ipc;
   logic [31:0] m_stall;

   initial begin
      vt[0]  = mk(0,16'h0000,0,0,0,16'h0000,0,0, 0,16'h0000,0,16'hffff,16'h0000,0,1);
      vt[1]  = mk(0,16'h0000,0,0,1,16'h2105,0,0, 1,16'h0000,0,16'hffff,16'h0000,0,1);
      vt[2]  = mk(0,16'h0000,0,0,0,16'h0000,1,0, 0,16'h0000,1,16'h2105,16'h0000,0,1);
      vt[3]  = mk(0,16'h0000,0,0,0,16'h0000,0,0, 1,16'h0001,0,16'h2105,16'h0000,0,1);
      vt[4]  = mk(1,16'h0040,0,0,1,16'hdead,0,0, 0,16'h0000,0,16'h2105,16'h0000,0,1);
      vt[5]  = mk(0,16'h0000,0,0,1,16'h1234,0,0, 1,16'h0040,0,16'h2105,16'h0000,0,1);
      vt[6]  = mk(0,16'h0000,1,0,0,16'h0000,0,0, 0,16'h0000,1,16'h1234,16'h0040,0,1);
      vt[7]  = mk(0,16'h0000,0,0,0,16'h0000,0,0, 0,16'h0000,0,16'h1234,16'h0040,1,1);
      vt[8]  = mk(0,16'h0000,1,1,0,16'h0000,0,0, 0,16'h0000,0,16'h1234,16'h0040,1,1);
      vt[9]  = mk(0,16'h0000,0,1,0,16'h0000,0,0, 0,16'h0000,0,16'h1234,16'h0040,1,1);
      vt[10] = mk(0,16'h0000,1,0,1,16'h5555,0,0, 1,16'h0041,0,16'h1234,16'h0040,0,1);
      vt[11] = mk(1,16'hffff,0,0,0,16'h0000,0,1, 0,16'h0000,0,16'h1234,16'h0040,1,1);
      vt[12] = mk(0,16'h0000,0,0,1,16'h7777,0,0, 1,16'hffff,0,16'h1234,16'h0040,0,0);
      vt[13] = mk(0,16'h0000,0,0,0,16'h0000,1,0, 0,16'h0000,1,16'h7777,16'hffff,0,0);
      vt[14] = mk(0,16'h0000,0,0,0,16'h0000,0,0, 1,16'h0000,0,16'h7777,16'hffff,0,0);

      // Values held in reset
      repeat (2) @(posedge clock);
      #1;
      check_out("reset", 0, 16'h0000, 0, 16'hffff, 16'h0000, 0, 1);
      reset = 1'b1;

      for (int i = 0; i < 15; i++) begin
         drive(vt[i].rv, vt[i].rpc, vt[i].hlt, vt[i].res, vt[i].ack, vt[i].rd, vt[i].rdy, vt[i].ose);
         #2;
         check_out($sformatf("row%0d", i), vt[i].e_req, vt[i].e_addr, vt[i].e_val,
                   vt[i].e_ins, vt[i].e_ipc, vt[i].e_hlt, vt[i].e_bios);
         next_cycle();
      end

      // Asynchronous reset while a request is outstanding
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      check("pre_reset imem_req", 32'(imem_req), 32'd1);
      reset = 1'b0;
      #1;
      check_out("async_reset", 0, 16'h0000, 0, 16'hffff, 16'h0000, 0, 1);
`ifdef FETCH_STALL_COUNTER_EN
      check("async_reset stall_cycles", stall_cycles, 32'd0);
`endif
      next_cycle();
      reset = 1'b1;
      #2;
      check_out("reboot", 0, 16'h0000, 0, 16'hffff, 16'h0000, 0, 1);
      next_cycle();

      // Ack delayed 3 cycles, then decoder not ready for 2 cycles
      for (int i = 0; i < 3; i++) begin
         drive(0, 0, 0, 0, 0, 16'hbeef, 0, 0);
         #2;
         check_out($sformatf("ack_wait%0d", i), 1, 16'h0000, 0, 16'hffff, 16'h0000, 0, 1);
         next_cycle();
      end
      drive(0, 0, 0, 0, 1, 16'habcd, 0, 0);
      #2;
      check_out("ack", 1, 16'h0000, 0, 16'hffff, 16'h0000, 0, 1);
      next_cycle();
      for (int i = 0; i < 2; i++) begin
         drive(0, 0, 0, 0, 0, 16'h0000, 0, 0);
         #2;
         check_out($sformatf("not_ready%0d", i), 0, 16'h0000, 1, 16'habcd, 16'h0000, 0, 1);
         next_cycle();
      end
      drive(0, 0, 0, 0, 0, 16'h0000, 1, 0);
      #2;
      check_out("ready", 0, 16'h0000, 1, 16'habcd, 16'h0000, 0, 1);
`ifdef FETCH_STALL_COUNTER_EN
      check("stall_cycles", stall_cycles, 32'd5);
`endif
      next_cycle();
      drive(0, 0, 0, 0, 0, 16'h0000, 0, 0);
      #2;
      check_out("next_fetch", 1, 16'h0001, 0, 16'habcd, 16'h0000, 0, 1);

      // Randomized run against the reference model
      reset = 1'b0;
      #1;
      reset = 1'b1;
      m_boot = 1; m_halted = 0; m_hold = 0; m_bios = 1;
      m_pc = 16'h0000; m_instr = 16'hffff; m_ipc = 16'h0000; m_stall = 32'd0;
      for (int c = 0; c < 2000; c++) begin
         logic rv, hlt, res, ack, rdy, ose, fetching, e_req;
         logic [15:0] rpc;
         rv  = ($urandom_range(15) == 0);
         rpc = ($urandom_range(7) == 0) ? 16'hffff : 16'($urandom);
         hlt = ($urandom_range(19) == 0);
         res = ($urandom_range(3) == 0);
         ack = ($urandom_range(1) == 0);
         rdy = ($urandom_range(1) == 0);
         ose = ($urandom_range(199) == 0);
         drive(rv, rpc, hlt, res, ack, mem_word(m_pc), rdy, ose);
         #1;
         fetching = !m_boot && !m_halted && !m_hold;
         e_req    = fetching && !rv;
         check_out($sformatf("rand%0d", c), e_req, m_pc, m_hold, m_instr, m_ipc, m_halted, m_bios);
`ifdef FETCH_STALL_COUNTER_EN
         check($sformatf("rand%0d stall_cycles", c), stall_cycles, m_stall);
         if (((e_req && !ack) || (m_hold && !rdy)) && m_stall != 32'hffffffff) m_stall++;
`endif
         if (ose) m_bios = 0;
         if (rv) begin
            m_pc = rpc; m_hold = 0; m_halted = 0; m_boot = 0;
         end else if (hlt) begin
            m_halted = 1; m_hold = 0; m_boot = 0;
         end else if (m_boot) begin
            m_boot = 0;
         end else if (m_halted) begin
            if (res) m_halted = 0;
         end else if (m_hold) begin
            if (rdy) m_hold = 0;
         end else if (ack) begin
            m_instr = mem_word(m_pc); m_ipc = m_pc; m_pc = m_pc + 16'd1; m_hold = 1;
         end
         next_cycle();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
